// File: rtl/croc_rst_ctrl_pkg.sv
// Shared types for the croc reset controller.
//   rst_cause_t       sticky reset-cause record {dbg, sw, wdt, por}
//   rst_ctrl_state_e  controller FSM states
//   RstCauseW         width of the packed cause vector
//   cnt_width()       counter width able to hold max(a, b)
package croc_rst_ctrl_pkg;

  localparam int unsigned RstCauseW = 4;

  typedef struct packed {
    logic dbg;
    logic sw;
    logic wdt;
    logic por;
  } rst_cause_t;

  typedef enum logic [1:0] {
    Hold    = 2'd0,
    RelCroc = 2'd1,
    Run     = 2'd2
  } rst_ctrl_state_e;

  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/croc_rst_ctrl.sv
// SoC reset controller: merges watchdog, software and debug reset requests, stretches each
// to a minimum hold window and releases the croc domain, then the user domain.
// Optional feature macro: CROC_RST_CTRL_DBG_EN (debug ndmreset participates when defined).
// Ports:
//   clk_i          system clock
//   rst_ni         pin reset, asynchronous, active-low
//   testmode_i     DFT mode, masks wdt/sw/dbg requests
//   wdt_rst_req_i  watchdog reset request (level)
//   sw_rst_req_i   software reset request (level)
//   dbg_rst_req_i  debug ndmreset request (level)
//   cause_clr_i    single-cycle pulse clearing cause bits [3:1] (and POR while running)
//   croc_rst_no    croc-domain reset, active-low, registered
//   user_rst_no    user-domain reset, active-low, registered
//   rst_active_o   high whenever the controller is not in Run
//   rst_cause_o    sticky cause vector {dbg, sw, wdt, por}
module croc_rst_ctrl
  import croc_rst_ctrl_pkg::*;
#(
  parameter int unsigned HoldCycles    = 16,
  parameter int unsigned StaggerCycles = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 testmode_i,
  input  logic                 wdt_rst_req_i,
  input  logic                 sw_rst_req_i,
  input  logic                 dbg_rst_req_i,
  input  logic                 cause_clr_i,
  output logic                 croc_rst_no,
  output logic                 user_rst_no,
  output logic                 rst_active_o,
  output logic [RstCauseW-1:0] rst_cause_o
);

  localparam int unsigned CntW = cnt_width(HoldCycles, StaggerCycles);
  localparam logic [CntW-1:0] HoldLast    = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(StaggerCycles - 1);

  rst_ctrl_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            croc_rst_q, croc_rst_d;
  logic            user_rst_q, user_rst_d;
  rst_cause_t      cause_q, cause_d;

  logic req_wdt, req_sw, req_dbg, req;

  assign req_wdt = ~testmode_i & wdt_rst_req_i;
  assign req_sw  = ~testmode_i & sw_rst_req_i;
`ifdef CROC_RST_CTRL_DBG_EN
  assign req_dbg = ~testmode_i & dbg_rst_req_i;
`else
  logic unused_dbg_rst_req;
  assign unused_dbg_rst_req = dbg_rst_req_i;
  assign req_dbg = 1'b0;
`endif
  assign req = req_wdt | req_sw | req_dbg;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Hold;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; one counter serves both the hold and the stagger windows.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      Hold: begin
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = RelCroc;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RelCroc: begin
        if (req) begin
          cnt_d   = '0;
          state_d = Hold;
        end else if (cnt_q == StaggerLast) begin
          cnt_d   = '0;
          state_d = Run;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      Run: begin
        if (req) begin
          cnt_d   = '0;
          state_d = Hold;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = Hold;
      end
    endcase
  end

  // Outputs: resets are decoded from the next state and registered so they never glitch.
  always_comb begin
    croc_rst_d   = (state_d != Hold);
    user_rst_d   = (state_d == Run);
    rst_active_o = (state_q != Run);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      croc_rst_q <= 1'b0;
      user_rst_q <= 1'b0;
    end else begin
      croc_rst_q <= croc_rst_d;
      user_rst_q <= user_rst_d;
    end
  end

  assign croc_rst_no = croc_rst_q;
  assign user_rst_no = user_rst_q;

  // Cause vector: clear first, then OR in requests so a same-cycle set wins.
  always_comb begin
    cause_d = cause_q;
    if (cause_clr_i) begin
      cause_d.dbg = 1'b0;
      cause_d.sw  = 1'b0;
      cause_d.wdt = 1'b0;
      if (state_q == Run) begin
        cause_d.por = 1'b0;
      end
    end
    cause_d.wdt = cause_d.wdt | req_wdt;
    cause_d.sw  = cause_d.sw | req_sw;
`ifdef CROC_RST_CTRL_DBG_EN
    cause_d.dbg = cause_d.dbg | req_dbg;
`else
    cause_d.dbg = 1'b0;
`endif
  end

  // Only the pin reset clears the record; the controller's own outputs never feed back here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q <= rst_cause_t'(4'b0001);
    end else begin
      cause_q <= cause_d;
    end
  end

  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_croc_rst_ctrl.sv
module tb_croc_rst_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       testmode_i, wdt_rst_req_i, sw_rst_req_i, dbg_rst_req_i, cause_clr_i;
  logic       croc_rst_no, user_rst_no, rst_active_o;
  logic [3:0] rst_cause_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  croc_rst_ctrl #(
    .HoldCycles   (16),
    .StaggerCycles(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .testmode_i   (testmode_i),
    .wdt_rst_req_i(wdt_rst_req_i),
    .sw_rst_req_i (sw_rst_req_i),
    .dbg_rst_req_i(dbg_rst_req_i),
    .cause_clr_i  (cause_clr_i),
    .croc_rst_no  (croc_rst_no),
    .user_rst_no  (user_rst_no),
    .rst_active_o (rst_active_o),
    .rst_cause_o  (rst_cause_o)
  );

  typedef struct {
    string       name;
    int unsigned n;
    logic        tm, wdt, sw, dbg, clr;
    logic        croc, user, act;
    logic [3:0]  cause;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic croc, input logic user, input logic act,
                         input logic [3:0] cause);
    chk({name, ".croc"}, {3'b0, croc_rst_no}, {3'b0, croc});
    chk({name, ".user"}, {3'b0, user_rst_no}, {3'b0, user});
    chk({name, ".act"}, {3'b0, rst_active_o}, {3'b0, act});
    chk({name, ".cause"}, rst_cause_o, cause);
  endtask

  function automatic vec_t mk(string name, int unsigned n, logic tm, logic wdt, logic sw,
                              logic clr, logic croc, logic user, logic act, logic [3:0] cause);
    vec_t v;
    v.name = name; v.n = n; v.tm = tm; v.wdt = wdt; v.sw = sw; v.dbg = 1'b0; v.clr = clr;
    v.croc = croc; v.user = user; v.act = act; v.cause = cause;
    return v;
  endfunction

  initial begin
    //            name          n  tm wdt sw clr  croc user act cause
    vecs.push_back(mk("hold15",     15, 0, 0, 0, 0, 0, 0, 1, 4'b0001));
    vecs.push_back(mk("croc_rel",    1, 0, 0, 0, 0, 1, 0, 1, 4'b0001));
    vecs.push_back(mk("stagger3",    3, 0, 0, 0, 0, 1, 0, 1, 4'b0001));
    vecs.push_back(mk("run",         1, 0, 0, 0, 0, 1, 1, 0, 4'b0001));
    vecs.push_back(mk("wdt_hit",     1, 0, 1, 0, 0, 0, 0, 1, 4'b0011));
    vecs.push_back(mk("wdt_hold15", 15, 0, 0, 0, 0, 0, 0, 1, 4'b0011));
    vecs.push_back(mk("wdt_rel",     1, 0, 0, 0, 0, 1, 0, 1, 4'b0011));
    vecs.push_back(mk("wdt_run",     4, 0, 0, 0, 0, 1, 1, 0, 4'b0011));
    vecs.push_back(mk("tm_mask",     5, 1, 1, 1, 0, 1, 1, 0, 4'b0011));
    vecs.push_back(mk("clr_run",     1, 0, 0, 0, 1, 1, 1, 0, 4'b0000));
    vecs.push_back(mk("clr_sw",      1, 0, 0, 1, 1, 0, 0, 1, 4'b0100));
    vecs.push_back(mk("hold10",     10, 0, 0, 0, 0, 0, 0, 1, 4'b0100));
    vecs.push_back(mk("sw_at10",     1, 0, 0, 1, 0, 0, 0, 1, 4'b0100));
    vecs.push_back(mk("sw_held",     3, 0, 0, 1, 0, 0, 0, 1, 4'b0100));
    vecs.push_back(mk("retrig15",   15, 0, 0, 0, 0, 0, 0, 1, 4'b0100));
    vecs.push_back(mk("retrig_rel",  1, 0, 0, 0, 0, 1, 0, 1, 4'b0100));

    rst_ni = 1'b0;
    testmode_i = 1'b0; wdt_rst_req_i = 1'b0; sw_rst_req_i = 1'b0;
    dbg_rst_req_i = 1'b0; cause_clr_i = 1'b0;
    #23;
    chk_all("reset", 1'b0, 1'b0, 1'b1, 4'b0001);

    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      testmode_i    = vecs[i].tm;
      wdt_rst_req_i = vecs[i].wdt;
      sw_rst_req_i  = vecs[i].sw;
      dbg_rst_req_i = vecs[i].dbg;
      cause_clr_i   = vecs[i].clr;
      repeat (vecs[i].n) @(posedge clk_i);
      #1;
      chk_all(vecs[i].name, vecs[i].croc, vecs[i].user, vecs[i].act, vecs[i].cause);
    end
    testmode_i = 1'b0; wdt_rst_req_i = 1'b0; sw_rst_req_i = 1'b0; cause_clr_i = 1'b0;

    // Debug request one cycle into the croc/user stagger window.
    dbg_rst_req_i = 1'b1;
    @(posedge clk_i);
    #1;
    dbg_rst_req_i = 1'b0;
`ifdef CROC_RST_CTRL_DBG_EN
    chk_all("dbg_hit", 1'b0, 1'b0, 1'b1, 4'b1100);
    repeat (15) @(posedge clk_i);
    #1;
    chk_all("dbg_hold15", 1'b0, 1'b0, 1'b1, 4'b1100);
    @(posedge clk_i);
    #1;
    chk_all("dbg_rel", 1'b1, 1'b0, 1'b1, 4'b1100);
`else
    chk_all("dbg_ignored", 1'b1, 1'b0, 1'b1, 4'b0100);
`endif

    // Pin reset in the middle of the stagger window acts immediately.
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk_all("pin_rst_async", 1'b0, 1'b0, 1'b1, 4'b0001);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk_all("pin_rst_hold", 1'b0, 1'b0, 1'b1, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
